// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the integer ALU.
//
// Holds up to DEPTH dispatched operations. Missing source operands are
// captured from the common data bus (CDB) by ROB tag. Each cycle the
// lowest-index operand-ready entry is moved into a registered issue stage.
// A flush empties every entry and the issue register.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush_i               synchronous clear of entries and issue register
//   disp_*                dispatch request / operation / operands / tags
//   disp_ready_o          at least one free entry (from busy bits only)
//   cdb_valid_i/tag/data  result broadcast for wakeup and dispatch bypass
//   issue_valid_o/ready_i registered issue handshake toward the ALU
//   issue_op_func_o, issue_oprand1_o, issue_oprand2_o, issue_dest_tag_o
//   occupancy_o           registered count of busy entries
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. On the dispatch side disp_ready_o never depends on
// disp_valid_i. On the issue side, once issue_valid_o is high the issue
// outputs are held unchanged until the edge at which issue_ready_i is seen
// high.

module alu_rs #(
  parameter int DEPTH         = 4,
  parameter int OPRAND_WIDTH  = 32,
  parameter int OP_FUNC_WIDTH = 17,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  logic [OP_FUNC_WIDTH-1:0]     disp_op_func_i,
  input  logic [TAG_WIDTH-1:0]         disp_dest_tag_i,
  input  logic [OPRAND_WIDTH-1:0]      disp_vj_i,
  input  logic [OPRAND_WIDTH-1:0]      disp_vk_i,
  input  logic                         disp_qj_valid_i,
  input  logic                         disp_qk_valid_i,
  input  logic [TAG_WIDTH-1:0]         disp_qj_i,
  input  logic [TAG_WIDTH-1:0]         disp_qk_i,
  input  logic                         cdb_valid_i,
  input  logic [TAG_WIDTH-1:0]         cdb_tag_i,
  input  logic [OPRAND_WIDTH-1:0]      cdb_data_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [OP_FUNC_WIDTH-1:0]     issue_op_func_o,
  output logic [OPRAND_WIDTH-1:0]      issue_oprand1_o,
  output logic [OPRAND_WIDTH-1:0]      issue_oprand2_o,
  output logic [TAG_WIDTH-1:0]         issue_dest_tag_o,
  output logic [$clog2(DEPTH):0]       occupancy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  // Entry storage
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [DEPTH-1:0]         qj_p_q, qj_p_d;
  logic [DEPTH-1:0]         qk_p_q, qk_p_d;
  logic [OP_FUNC_WIDTH-1:0] op_q   [DEPTH];
  logic [OP_FUNC_WIDTH-1:0] op_d   [DEPTH];
  logic [TAG_WIDTH-1:0]     dest_q [DEPTH];
  logic [TAG_WIDTH-1:0]     dest_d [DEPTH];
  logic [OPRAND_WIDTH-1:0]  vj_q   [DEPTH];
  logic [OPRAND_WIDTH-1:0]  vj_d   [DEPTH];
  logic [OPRAND_WIDTH-1:0]  vk_q   [DEPTH];
  logic [OPRAND_WIDTH-1:0]  vk_d   [DEPTH];
  logic [TAG_WIDTH-1:0]     qj_q   [DEPTH];
  logic [TAG_WIDTH-1:0]     qj_d   [DEPTH];
  logic [TAG_WIDTH-1:0]     qk_q   [DEPTH];
  logic [TAG_WIDTH-1:0]     qk_d   [DEPTH];

  // Issue register
  logic                     issue_valid_q, issue_valid_d;
  logic [OP_FUNC_WIDTH-1:0] issue_op_q, issue_op_d;
  logic [OPRAND_WIDTH-1:0]  issue_o1_q, issue_o1_d;
  logic [OPRAND_WIDTH-1:0]  issue_o2_q, issue_o2_d;
  logic [TAG_WIDTH-1:0]     issue_dest_q, issue_dest_d;

  logic [OCC_W-1:0]         occupancy_q, occupancy_d;

  // Select / allocate helpers
  logic [DEPTH-1:0]         rdy;
  logic [IDX_W-1:0]         free_idx;
  logic [IDX_W-1:0]         sel_idx;
  logic                     load_en;
  logic                     issue_load;
  logic                     disp_fire;

  always_comb begin
    rdy = busy_q & ~qj_p_q & ~qk_p_q;

    // Descending scans so the lowest matching index wins.
    free_idx = '0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (rdy[i])     sel_idx  = IDX_W'(i);
    end

    // Only current busy bits count: a slot freed by this cycle's issue
    // load is not offered to dispatch until the next cycle.
    disp_ready_o = ~&busy_q;
    disp_fire    = disp_valid_i && disp_ready_o;
    load_en      = !issue_valid_q || issue_ready_i;
    issue_load   = load_en && |rdy;
  end

  always_comb begin
    busy_d        = busy_q;
    qj_p_d        = qj_p_q;
    qk_p_d        = qk_p_q;
    op_d          = op_q;
    dest_d        = dest_q;
    vj_d          = vj_q;
    vk_d          = vk_q;
    qj_d          = qj_q;
    qk_d          = qk_q;
    issue_valid_d = issue_valid_q;
    issue_op_d    = issue_op_q;
    issue_o1_d    = issue_o1_q;
    issue_o2_d    = issue_o2_q;
    issue_dest_d  = issue_dest_q;

    if (flush_i) begin
      busy_d        = '0;
      issue_valid_d = 1'b0;
    end else begin
      // Wakeup: both operands of an entry may match the same broadcast.
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && cdb_valid_i) begin
          if (qj_p_q[i] && (qj_q[i] == cdb_tag_i)) begin
            vj_d[i]   = cdb_data_i;
            qj_p_d[i] = 1'b0;
          end
          if (qk_p_q[i] && (qk_q[i] == cdb_tag_i)) begin
            vk_d[i]   = cdb_data_i;
            qk_p_d[i] = 1'b0;
          end
        end
      end

      // A ready entry has no pending operand, so its stored values are
      // final and wakeup above cannot change them.
      if (issue_load) begin
        issue_valid_d   = 1'b1;
        issue_op_d      = op_q[sel_idx];
        issue_o1_d      = vj_q[sel_idx];
        issue_o2_d      = vk_q[sel_idx];
        issue_dest_d    = dest_q[sel_idx];
        busy_d[sel_idx] = 1'b0;
      end else if (load_en) begin
        issue_valid_d = 1'b0;
      end

      // free_idx is never busy, so it cannot collide with sel_idx.
      if (disp_fire) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op_func_i;
        dest_d[free_idx] = disp_dest_tag_i;
        qj_d[free_idx]   = disp_qj_i;
        qk_d[free_idx]   = disp_qk_i;
        // Bypass: a producer broadcasting in the dispatch cycle is caught here.
        if (disp_qj_valid_i && cdb_valid_i && (disp_qj_i == cdb_tag_i)) begin
          vj_d[free_idx]   = cdb_data_i;
          qj_p_d[free_idx] = 1'b0;
        end else begin
          vj_d[free_idx]   = disp_vj_i;
          qj_p_d[free_idx] = disp_qj_valid_i;
        end
        if (disp_qk_valid_i && cdb_valid_i && (disp_qk_i == cdb_tag_i)) begin
          vk_d[free_idx]   = cdb_data_i;
          qk_p_d[free_idx] = 1'b0;
        end else begin
          vk_d[free_idx]   = disp_vk_i;
          qk_p_d[free_idx] = disp_qk_valid_i;
        end
      end
    end

    occupancy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + OCC_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      qj_p_q        <= '0;
      qk_p_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_o1_q    <= '0;
      issue_o2_q    <= '0;
      issue_dest_q  <= '0;
      occupancy_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      qj_p_q        <= qj_p_d;
      qk_p_q        <= qk_p_d;
      op_q          <= op_d;
      dest_q        <= dest_d;
      vj_q          <= vj_d;
      vk_q          <= vk_d;
      qj_q          <= qj_d;
      qk_q          <= qk_d;
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      issue_o1_q    <= issue_o1_d;
      issue_o2_q    <= issue_o2_d;
      issue_dest_q  <= issue_dest_d;
      occupancy_q   <= occupancy_d;
    end
  end

  assign issue_valid_o    = issue_valid_q;
  assign issue_op_func_o  = issue_op_q;
  assign issue_oprand1_o  = issue_o1_q;
  assign issue_oprand2_o  = issue_o2_q;
  assign issue_dest_tag_o = issue_dest_q;
  assign occupancy_o      = occupancy_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs (directed table, hand-written
// multi-cycle sequences, and random stimulus against a reference model).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
// the edge, well away from the next one.

module tb_alu_rs;

  localparam int DEPTH = 4;
  localparam int OW    = 32;
  localparam int FW    = 17;
  localparam int TW    = 4;

  localparam logic [FW-1:0] OP_ADD  = 17'b0000000_000_0110011;
  localparam logic [FW-1:0] OP_SUB  = 17'b0100000_000_0110011;
  localparam logic [FW-1:0] OP_ADDI = 17'b0000000_000_0010011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          disp_valid_i = 1'b0;
  logic          disp_ready_o;
  logic [FW-1:0] disp_op_func_i = '0;
  logic [TW-1:0] disp_dest_tag_i = '0;
  logic [OW-1:0] disp_vj_i = '0;
  logic [OW-1:0] disp_vk_i = '0;
  logic          disp_qj_valid_i = 1'b0;
  logic          disp_qk_valid_i = 1'b0;
  logic [TW-1:0] disp_qj_i = '0;
  logic [TW-1:0] disp_qk_i = '0;
  logic          cdb_valid_i = 1'b0;
  logic [TW-1:0] cdb_tag_i = '0;
  logic [OW-1:0] cdb_data_i = '0;
  logic          issue_valid_o;
  logic          issue_ready_i = 1'b1;
  logic [FW-1:0] issue_op_func_o;
  logic [OW-1:0] issue_oprand1_o;
  logic [OW-1:0] issue_oprand2_o;
  logic [TW-1:0] issue_dest_tag_o;
  logic [2:0]    occupancy_o;

  alu_rs #(.DEPTH(DEPTH), .OPRAND_WIDTH(OW), .OP_FUNC_WIDTH(FW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_op_func_i(disp_op_func_i), .disp_dest_tag_i(disp_dest_tag_i),
    .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i),
    .disp_qj_valid_i(disp_qj_valid_i), .disp_qk_valid_i(disp_qk_valid_i),
    .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_op_func_o(issue_op_func_o), .issue_oprand1_o(issue_oprand1_o),
    .issue_oprand2_o(issue_oprand2_o), .issue_dest_tag_o(issue_dest_tag_o),
    .occupancy_o(occupancy_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    flush_i = 1'b0; disp_valid_i = 1'b0; disp_op_func_i = '0; disp_dest_tag_i = '0;
    disp_vj_i = '0; disp_vk_i = '0; disp_qj_valid_i = 1'b0; disp_qk_valid_i = 1'b0;
    disp_qj_i = '0; disp_qk_i = '0; cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_data_i = '0;
  endtask

  task automatic set_disp(input logic [FW-1:0] op, input logic [TW-1:0] dest,
                          input logic [OW-1:0] vj, input logic [OW-1:0] vk,
                          input logic qjv, input logic [TW-1:0] qj,
                          input logic qkv, input logic [TW-1:0] qk);
    disp_valid_i = 1'b1; disp_op_func_i = op; disp_dest_tag_i = dest;
    disp_vj_i = vj; disp_vk_i = vk; disp_qj_valid_i = qjv; disp_qj_i = qj;
    disp_qk_valid_i = qkv; disp_qk_i = qk;
  endtask

  task automatic set_cdb(input logic v, input logic [TW-1:0] tag, input logic [OW-1:0] data);
    cdb_valid_i = v; cdb_tag_i = tag; cdb_data_i = data;
  endtask

  // Reference model: a slot table plus one issue slot, advanced once per
  // cycle from the same inputs the DUT sees.
  typedef struct {
    bit            busy;
    logic [FW-1:0] op;
    logic [TW-1:0] dest;
    logic [OW-1:0] vj, vk;
    bit            jp, kp;
    logic [TW-1:0] qj, qk;
  } slot_t;

  slot_t         m_rs [DEPTH];
  bit            m_iv;
  logic [FW-1:0] m_op;
  logic [OW-1:0] m_o1, m_o2;
  logic [TW-1:0] m_dest;
  bit            model_on = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_rs[i].busy = 1'b0;
    m_iv = 1'b0; m_op = '0; m_o1 = '0; m_o2 = '0; m_dest = '0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_rs[i].busy) n++;
    return n;
  endfunction

  task automatic model_step();
    slot_t nx [DEPTH];
    int    fr = -1;
    int    sel = -1;
    nx = m_rs;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_rs[i].busy && fr < 0) fr = i;
      if (m_rs[i].busy && !m_rs[i].jp && !m_rs[i].kp && sel < 0) sel = i;
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) nx[i].busy = 1'b0;
      m_iv = 1'b0;
    end else begin
      if (!m_iv || issue_ready_i) begin
        if (sel >= 0) begin
          m_iv = 1'b1; m_op = m_rs[sel].op; m_o1 = m_rs[sel].vj;
          m_o2 = m_rs[sel].vk; m_dest = m_rs[sel].dest;
          nx[sel].busy = 1'b0;
        end else begin
          m_iv = 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_rs[i].busy && cdb_valid_i) begin
          if (m_rs[i].jp && m_rs[i].qj == cdb_tag_i) begin nx[i].vj = cdb_data_i; nx[i].jp = 1'b0; end
          if (m_rs[i].kp && m_rs[i].qk == cdb_tag_i) begin nx[i].vk = cdb_data_i; nx[i].kp = 1'b0; end
        end
      end
      if (disp_valid_i && fr >= 0) begin
        nx[fr].busy = 1'b1; nx[fr].op = disp_op_func_i; nx[fr].dest = disp_dest_tag_i;
        nx[fr].qj = disp_qj_i; nx[fr].qk = disp_qk_i;
        nx[fr].jp = disp_qj_valid_i; nx[fr].kp = disp_qk_valid_i;
        nx[fr].vj = disp_vj_i; nx[fr].vk = disp_vk_i;
        if (disp_qj_valid_i && cdb_valid_i && disp_qj_i == cdb_tag_i) begin
          nx[fr].vj = cdb_data_i; nx[fr].jp = 1'b0;
        end
        if (disp_qk_valid_i && cdb_valid_i && disp_qk_i == cdb_tag_i) begin
          nx[fr].vk = cdb_data_i; nx[fr].kp = 1'b0;
        end
      end
    end
    m_rs = nx;
  endtask

  // One clock: inputs already applied; outputs settle 1 ns after the edge.
  task automatic step();
    if (model_on) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_iv"},    OW'(issue_valid_o), 0);
    check({tag, "_occ"},   OW'(occupancy_o), 0);
    check({tag, "_rdy"},   OW'(disp_ready_o), 1);
    check({tag, "_o1"},    issue_oprand1_o, 0);
    check({tag, "_o2"},    issue_oprand2_o, 0);
    check({tag, "_dest"},  OW'(issue_dest_tag_o), 0);
    check({tag, "_op"},    OW'(issue_op_func_o), 0);
  endtask

  // Directed table
  typedef struct {
    logic          dv;
    logic [FW-1:0] op;
    logic [TW-1:0] dest;
    logic [OW-1:0] vj, vk;
    logic          qjv;
    logic [TW-1:0] qj;
    logic          qkv;
    logic [TW-1:0] qk;
    logic          cv;
    logic [TW-1:0] ctag;
    logic [OW-1:0] cdata;
    logic          e_iv;
    logic [OW-1:0] e_o1, e_o2;
    logic [TW-1:0] e_dest;
    logic [2:0]    e_occ;
  } vec_t;

  function automatic vec_t mkv(logic dv, logic [FW-1:0] op, logic [TW-1:0] dest,
                               logic [OW-1:0] vj, logic [OW-1:0] vk,
                               logic qjv, logic [TW-1:0] qj, logic qkv, logic [TW-1:0] qk,
                               logic cv, logic [TW-1:0] ctag, logic [OW-1:0] cdata,
                               logic e_iv, logic [OW-1:0] e_o1, logic [OW-1:0] e_o2,
                               logic [TW-1:0] e_dest, logic [2:0] e_occ);
    vec_t v;
    v.dv = dv; v.op = op; v.dest = dest; v.vj = vj; v.vk = vk;
    v.qjv = qjv; v.qj = qj; v.qkv = qkv; v.qk = qk;
    v.cv = cv; v.ctag = ctag; v.cdata = cdata;
    v.e_iv = e_iv; v.e_o1 = e_o1; v.e_o2 = e_o2; v.e_dest = e_dest; v.e_occ = e_occ;
    return v;
  endfunction

  function automatic vec_t idle(logic e_iv, logic [OW-1:0] e_o1, logic [OW-1:0] e_o2,
                                logic [TW-1:0] e_dest, logic [2:0] e_occ);
    return mkv(0, '0, '0, '0, '0, 0, '0, 0, '0, 0, '0, '0, e_iv, e_o1, e_o2, e_dest, e_occ);
  endfunction

  vec_t tbl [13];

  initial begin
    // Simple issue, wakeup, dispatch bypass
    tbl[0]  = mkv(1, OP_ADD, 4'd3, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 0, 4'd0, 32'd0, 0, 0, 0, 0, 3'd1);
    tbl[1]  = idle(1, 32'd5, 32'd7, 4'd3, 3'd0);
    tbl[2]  = idle(0, 0, 0, 0, 3'd0);
    tbl[3]  = mkv(1, OP_SUB, 4'd4, 32'd0, 32'd1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 32'd0, 0, 0, 0, 0, 3'd1);
    tbl[4]  = idle(0, 0, 0, 0, 3'd1);
    tbl[5]  = idle(0, 0, 0, 0, 3'd1);
    tbl[6]  = idle(0, 0, 0, 0, 3'd1);
    tbl[7]  = mkv(0, '0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 0, 4'd0, 1, 4'd2, 32'd10, 0, 0, 0, 0, 3'd1);
    tbl[8]  = idle(1, 32'd10, 32'd1, 4'd4, 3'd0);
    tbl[9]  = idle(0, 0, 0, 0, 3'd0);
    tbl[10] = mkv(1, OP_ADDI, 4'd5, 32'd3, 32'd0, 0, 4'd0, 1, 4'd6, 1, 4'd6, 32'hFFFF_FFFF,
                  0, 0, 0, 0, 3'd1);
    tbl[11] = idle(1, 32'd3, 32'hFFFF_FFFF, 4'd5, 3'd0);
    tbl[12] = idle(0, 0, 0, 0, 3'd0);

    do_reset();
    check_reset_values("reset");

    // Table-driven directed vectors
    issue_ready_i = 1'b1;
    for (int r = 0; r < 13; r++) begin
      clear_inputs();
      if (tbl[r].dv) set_disp(tbl[r].op, tbl[r].dest, tbl[r].vj, tbl[r].vk,
                              tbl[r].qjv, tbl[r].qj, tbl[r].qkv, tbl[r].qk);
      set_cdb(tbl[r].cv, tbl[r].ctag, tbl[r].cdata);
      step();
      check($sformatf("tbl%0d_iv", r),  OW'(issue_valid_o), OW'(tbl[r].e_iv));
      check($sformatf("tbl%0d_occ", r), OW'(occupancy_o), OW'(tbl[r].e_occ));
      check($sformatf("tbl%0d_rdy", r), OW'(disp_ready_o), 1);
      if (tbl[r].e_iv) begin
        check($sformatf("tbl%0d_o1", r),   issue_oprand1_o, tbl[r].e_o1);
        check($sformatf("tbl%0d_o2", r),   issue_oprand2_o, tbl[r].e_o2);
        check($sformatf("tbl%0d_dest", r), OW'(issue_dest_tag_o), OW'(tbl[r].e_dest));
      end
    end
    clear_inputs();

    // Full and back-pressure: the issue register adds one slot of capacity,
    // so five ready ops fit before dispatch stalls.
    issue_ready_i = 1'b0;
    for (int t = 0; t < 5; t++) begin
      check($sformatf("bp_rdy_before%0d", t), OW'(disp_ready_o), 1);
      set_disp(OP_ADD, TW'(t), OW'(t * 16 + 1), OW'(t), 0, '0, 0, '0);
      step();
    end
    set_disp(OP_ADD, 4'd5, 32'd81, 32'd5, 0, '0, 0, '0);
    check("bp_full_rdy", OW'(disp_ready_o), 0);
    check("bp_full_occ", OW'(occupancy_o), 4);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("bp_stall%0d_iv", s),   OW'(issue_valid_o), 1);
      check($sformatf("bp_stall%0d_dest", s), OW'(issue_dest_tag_o), 0);
      check($sformatf("bp_stall%0d_o1", s),   issue_oprand1_o, 1);
      check($sformatf("bp_stall%0d_occ", s),  OW'(occupancy_o), 4);
      check($sformatf("bp_stall%0d_rdy", s),  OW'(disp_ready_o), 0);
    end
    clear_inputs();
    issue_ready_i = 1'b1;
    begin
      int order [4] = '{2, 1, 3, 4};
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("bp_rel%0d_iv", k),   OW'(issue_valid_o), 1);
        check($sformatf("bp_rel%0d_dest", k), OW'(issue_dest_tag_o), OW'(order[k]));
        check($sformatf("bp_rel%0d_o1", k),   issue_oprand1_o, OW'(order[k] * 16 + 1));
        check($sformatf("bp_rel%0d_o2", k),   issue_oprand2_o, OW'(order[k]));
        check($sformatf("bp_rel%0d_occ", k),  OW'(occupancy_o), OW'(3 - k));
        check($sformatf("bp_rel%0d_rdy", k),  OW'(disp_ready_o), 1);
      end
    end
    step();
    check("bp_drain_iv", OW'(issue_valid_o), 0);

    // Select priority: entry 1 ready first, then 0 and 2 woken together
    set_disp(OP_ADD, 4'd8, 32'd0, 32'd2, 1, 4'd9, 0, '0);
    step();
    check("sp0_iv", OW'(issue_valid_o), 0);
    check("sp0_occ", OW'(occupancy_o), 1);
    set_disp(OP_ADD, 4'd10, 32'd20, 32'd21, 0, '0, 0, '0);
    step();
    check("sp1_occ", OW'(occupancy_o), 2);
    set_disp(OP_SUB, 4'd11, 32'd30, 32'd0, 0, '0, 1, 4'd9);
    step();
    check("sp2_iv", OW'(issue_valid_o), 1);
    check("sp2_dest", OW'(issue_dest_tag_o), 10);
    check("sp2_o1", issue_oprand1_o, 20);
    check("sp2_occ", OW'(occupancy_o), 2);
    clear_inputs();
    set_cdb(1, 4'd9, 32'd77);
    step();
    check("sp3_iv", OW'(issue_valid_o), 0);
    clear_inputs();
    step();
    check("sp4_dest", OW'(issue_dest_tag_o), 8);
    check("sp4_o1", issue_oprand1_o, 77);
    check("sp4_o2", issue_oprand2_o, 2);
    step();
    check("sp5_dest", OW'(issue_dest_tag_o), 11);
    check("sp5_o1", issue_oprand1_o, 30);
    check("sp5_o2", issue_oprand2_o, 77);
    check("sp5_occ", OW'(occupancy_o), 0);
    step();
    check("sp6_iv", OW'(issue_valid_o), 0);

    // Flush with a dispatch in the same cycle
    issue_ready_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      set_disp(OP_ADD, TW'(t), OW'(t), OW'(t), 0, '0, 0, '0);
      step();
    end
    check("fl_pre_occ", OW'(occupancy_o), 3);
    check("fl_pre_iv", OW'(issue_valid_o), 1);
    set_disp(OP_ADD, 4'd9, 32'd9, 32'd9, 0, '0, 0, '0);
    flush_i = 1'b1;
    step();
    check("fl_occ", OW'(occupancy_o), 0);
    check("fl_iv", OW'(issue_valid_o), 0);
    check("fl_rdy", OW'(disp_ready_o), 1);
    clear_inputs();
    step();
    check("fl_post_occ", OW'(occupancy_o), 0);
    check("fl_post_iv", OW'(issue_valid_o), 0);

    // Asynchronous reset in the middle of a stall
    set_disp(OP_ADD, 4'd7, 32'd7, 32'd7, 0, '0, 0, '0);
    step();
    set_disp(OP_ADD, 4'd8, 32'd8, 32'd8, 0, '0, 0, '0);
    step();
    clear_inputs();
    step();
    check("ar_pre_iv", OW'(issue_valid_o), 1);
    check("ar_pre_dest", OW'(issue_dest_tag_o), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    do_reset();

    // Random stimulus against the reference model
    model_reset();
    model_on = 1'b1;
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      flush_i       = ($urandom_range(0, 39) == 0);
      issue_ready_i = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 1)
        set_disp(FW'($urandom), TW'($urandom_range(0, 15)), $urandom, $urandom,
                 $urandom_range(0, 1) == 1, TW'($urandom_range(0, 5)),
                 $urandom_range(0, 1) == 1, TW'($urandom_range(0, 5)));
      if ($urandom_range(0, 1) == 1)
        set_cdb(1, TW'($urandom_range(0, 5)), $urandom);
      step();
      check($sformatf("rnd%0d_iv", c),  OW'(issue_valid_o), OW'(m_iv));
      check($sformatf("rnd%0d_occ", c), OW'(occupancy_o), OW'(model_count()));
      check($sformatf("rnd%0d_rdy", c), OW'(disp_ready_o), OW'(model_count() < DEPTH));
      if (m_iv) begin
        check($sformatf("rnd%0d_op", c),   OW'(issue_op_func_o), OW'(m_op));
        check($sformatf("rnd%0d_o1", c),   issue_oprand1_o, m_o1);
        check($sformatf("rnd%0d_o2", c),   issue_oprand2_o, m_o2);
        check($sformatf("rnd%0d_dest", c), OW'(issue_dest_tag_o), OW'(m_dest));
      end
    end
    model_on = 1'b0;

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
